seq_gen_tx: RTL and testbench

SEQ_GEN_TX -- requirements
Module: seq_gen_tx

---
 rtl/seq_gen_tx_pkg.sv | 21 ++
 rtl/seq_bit_counter.sv | 30 +++
 rtl/seq_gen_tx.sv | 150 +++++++++++++++
 tb/tb_seq_gen_tx.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/seq_gen_tx_pkg.sv
// Shared definitions for the 1011-framed serial transmitter and its matching Mealy detector.
// Holds the FSM state type, the default sync pattern and a small sizing helper.
package seq_gen_tx_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SYNC = 2'd1,
    S_DATA = 2'd2,
    S_GAP  = 2'd3
  } state_t;

  localparam int         SEQ_SYNC_W   = 4;
  localparam logic [3:0] SEQ_SYNC_PAT = 4'b1011;

  function automatic int seq_max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/seq_bit_counter.sv
// Loadable down-counter with zero flag; load wins over decrement, and it saturates at zero.
// Single-cycle update, no handshake.
module seq_bit_counter #(
  parameter int W = 4
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic [W-1:0] o_cnt,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_cnt  = r_cnt;
  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/seq_gen_tx.sv
// Serial frame transmitter: sync pattern, payload MSB first, then GAP forced zeros.
// First sync bit one cycle after capture; in_ready only in IDLE, in_valid ignored while busy.
module seq_gen_tx
  import seq_gen_tx_pkg::*;
#(
  parameter int                DATA_W   = 8,
  parameter int                SYNC_W   = SEQ_SYNC_W,
  parameter logic [SYNC_W-1:0] SYNC_PAT = SYNC_W'(SEQ_SYNC_PAT),
  parameter int                GAP      = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out,
  output logic              busy,
  output logic              frame_done
);

  localparam int CNT_W = $clog2(seq_max3(SYNC_W, DATA_W, GAP) + 1);
  localparam logic [CNT_W-1:0] SYNC_LD = CNT_W'(SYNC_W - 1);
  localparam logic [CNT_W-1:0] DATA_LD = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] GAP_LD  = (GAP > 0) ? CNT_W'(GAP - 1) : '0;

  state_t              r_state;
  logic [DATA_W-1:0]   r_sh;
  logic [SYNC_W-1:0]   r_sync;
  logic                r_out;
  logic                r_busy;
  logic                r_rdy;
  logic                r_fd;
  logic                w_load;
  logic                w_dec;
  logic [CNT_W-1:0]    w_load_val;
  logic [CNT_W-1:0]    w_cnt;
  logic                w_zero;

  // Counter holds the number of bits still to go in the current state after this one.
  always_comb begin
    w_load     = 1'b0;
    w_dec      = 1'b0;
    w_load_val = '0;
    case (r_state)
      S_IDLE: begin
        w_load     = in_valid;
        w_load_val = SYNC_LD;
      end
      S_SYNC: begin
        w_load     = w_zero;
        w_dec      = !w_zero;
        w_load_val = DATA_LD;
      end
      S_DATA: begin
        w_load     = w_zero;
        w_dec      = !w_zero;
        w_load_val = GAP_LD;
      end
      S_GAP: begin
        w_load = w_zero;
        w_dec  = !w_zero;
      end
      default: w_load = 1'b1;
    endcase
  end

  seq_bit_counter #(.W(CNT_W)) u_cnt (
    .i_clk      (clk),
    .i_rst_n    (rst),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .i_dec      (w_dec),
    .o_cnt      (w_cnt),
    .o_zero     (w_zero)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_sh    <= '0;
      r_sync  <= '0;
      r_out   <= 1'b0;
      r_busy  <= 1'b0;
      r_rdy   <= 1'b1;
      r_fd    <= 1'b0;
    end else begin
      r_out <= 1'b0;
      r_fd  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_state <= S_SYNC;
            r_sh    <= in_data;
            r_sync  <= SYNC_PAT << 1;
            r_out   <= SYNC_PAT[SYNC_W-1];
            r_rdy   <= 1'b0;
            r_busy  <= 1'b1;
          end
        end
        S_SYNC: begin
          if (w_zero) begin
            r_state <= S_DATA;
            r_out   <= r_sh[DATA_W-1];
            r_sh    <= r_sh << 1;
            r_fd    <= (GAP == 0) && (DATA_W == 1);
          end else begin
            r_out  <= r_sync[SYNC_W-1];
            r_sync <= r_sync << 1;
          end
        end
        S_DATA: begin
          if (w_zero) begin
            if (GAP > 0) begin
              r_state <= S_GAP;
              r_fd    <= (GAP == 1);
            end else begin
              r_state <= S_IDLE;
              r_rdy   <= 1'b1;
              r_busy  <= 1'b0;
            end
          end else begin
            r_out <= r_sh[DATA_W-1];
            r_sh  <= r_sh << 1;
            r_fd  <= (GAP == 0) && (w_cnt == CNT_W'(1));
          end
        end
        S_GAP: begin
          if (w_zero) begin
            r_state <= S_IDLE;
            r_rdy   <= 1'b1;
            r_busy  <= 1'b0;
          end else begin
            r_fd <= (w_cnt == CNT_W'(1));
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_rdy   <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign out        = r_out;
  assign busy       = r_busy;
  assign in_ready   = r_rdy;
  assign frame_done = r_fd;

endmodule

// File: tb/tb_seq_gen_tx.sv
// Directed bench for seq_gen_tx: GAP=2 and GAP=0 instances, bit streams checked against hand-built frames.
// A behavioural 1011 Mealy detector watches the GAP=2 output for the loopback case.
module tb_seq_gen_tx;

  logic       clk;
  logic       rst;
  logic       in_valid, in_ready, out, busy, frame_done;
  logic [7:0] in_data;
  logic       v0, rdy0, out0, busy0, fd0;
  logic [7:0] d0;

  int n_chk  = 0;
  int n_pass = 0;
  int det_cnt = 0;
  logic [2:0] hist = '0;

  seq_gen_tx #(.DATA_W(8), .SYNC_W(4), .SYNC_PAT(4'b1011), .GAP(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out(out), .busy(busy), .frame_done(frame_done)
  );

  seq_gen_tx #(.DATA_W(8), .SYNC_W(4), .SYNC_PAT(4'b1011), .GAP(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(v0), .in_data(d0),
    .in_ready(rdy0), .out(out0), .busy(busy0), .frame_done(fd0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst) begin
      hist = '0;
    end else begin
      if ({hist, out} == 4'b1011) det_cnt++;
      hist = {hist[1:0], out};
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got=%h expected=%h", tag, got, exp);
  endtask

  task automatic send_frame(input logic [7:0] d, input int n,
                            output logic [31:0] bits, output logic [31:0] fds,
                            output logic [31:0] bsy);
    bits = '0; fds = '0; bsy = '0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clk);
    #1 in_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bits = {bits[30:0], out};
      fds  = {fds[30:0], frame_done};
      bsy  = {bsy[30:0], busy};
    end
  endtask

  task automatic idle_watch(input int n, output logic [31:0] act);
    act = '0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      act = {act[30:0], (out | busy | frame_done)};
    end
  endtask

  logic [31:0] bits, fds, bsy, act;
  int          det0;
  logic        fd_seen, out_seen;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; v0 = 1'b0; d0 = '0;
    #3 rst = 1'b0;
    #10;
    chk("rst_out", 32'(out), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_fd", 32'(frame_done), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Single frame straight after reset release
    send_frame(8'hA5, 14, bits, fds, bsy);
    chk("a5_bits", bits, 32'({4'b1011, 8'hA5, 2'b00}));
    chk("a5_fd", fds, 32'd1);
    chk("a5_busy", bsy, 32'h3FFF);
    chk("a5_rdy_k14", 32'(in_ready), 32'd0);
    @(negedge clk);
    chk("a5_rdy_k15", 32'(in_ready), 32'd1);

    // Back-to-back with in_valid held high
    bits = '0; fds = '0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'hFF;
    @(posedge clk);
    #1 in_data = 8'h00;
    for (int i = 1; i <= 29; i++) begin
      @(negedge clk);
      bits = {bits[30:0], out};
      fds  = {fds[30:0], frame_done};
      if (i == 15) chk("b2b_idle_rdy", 32'(in_ready), 32'd1);
      if (i == 16) in_valid = 1'b0;
    end
    chk("b2b_bits", bits, 32'({4'b1011, 8'hFF, 3'b000, 4'b1011, 8'h00, 2'b00}));
    chk("b2b_fd", fds, 32'({13'd0, 1'b1, 14'd0, 1'b1}));
    idle_watch(5, act);
    chk("b2b_no_third", act, 32'd0);

    // GAP=0 instance
    bits = '0; fds = '0;
    @(negedge clk);
    v0 = 1'b1;
    d0 = 8'h01;
    @(posedge clk);
    #1 v0 = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      bits = {bits[30:0], out0};
      fds  = {fds[30:0], fd0};
    end
    chk("gap0_bits", bits, 32'({4'b1011, 8'h01}));
    chk("gap0_fd", fds, 32'd1);
    @(negedge clk);
    chk("gap0_rdy", 32'(rdy0), 32'd1);
    chk("gap0_busy", 32'(busy0), 32'd0);

    // Reset during data bit 3
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'hFF;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (8) @(negedge clk);
    chk("mid_bit3_out", 32'(out), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_out", 32'(out), 32'd0);
    chk("mid_rst_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    fd_seen  = frame_done;
    out_seen = out;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      fd_seen  = fd_seen | frame_done;
      out_seen = out_seen | out;
    end
    chk("mid_no_fd", 32'(fd_seen), 32'd0);
    chk("mid_no_out", 32'(out_seen), 32'd0);
    send_frame(8'hA5, 14, bits, fds, bsy);
    chk("mid_clean_bits", bits, 32'({4'b1011, 8'hA5, 2'b00}));
    chk("mid_clean_fd", fds, 32'd1);

    // Input churn while busy
    bits = '0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'h3C;
    @(posedge clk);
    #1;
    for (int i = 1; i <= 14; i++) begin
      @(negedge clk);
      bits     = {bits[30:0], out};
      in_valid = (i < 13) ? (i % 2 == 1) : 1'b0;
      in_data  = 8'(i * 37);
    end
    chk("churn_bits", bits, 32'({4'b1011, 8'h3C, 2'b00}));
    idle_watch(6, act);
    chk("churn_no_extra", act, 32'd0);

    // Loopback into the 1011 detector
    det0 = det_cnt;
    send_frame(8'h00, 14, bits, fds, bsy);
    @(negedge clk);
    chk("loop_00_det", 32'(det_cnt - det0), 32'd1);
    det0 = det_cnt;
    send_frame(8'hF0, 14, bits, fds, bsy);
    @(negedge clk);
    chk("loop_f0_det", 32'(det_cnt - det0), 32'd1);
    chk("loop_f0_bits", bits, 32'({4'b1011, 8'hF0, 2'b00}));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
